// File: rtl/store_buffer_pkg.sv
// Shared constants and types for the store path. The load path uses the same
// access-size codes and byte-enable width.
package store_buffer_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int BE_W   = 4;

    // Access-size codes carried on st_sel
    typedef enum logic [2:0] {
        ST_SB = 3'b000,
        ST_SH = 3'b001,
        ST_SW = 3'b010
    } st_size_e;

    // One queued store: word address, lane-replicated data, byte enables
    typedef struct packed {
        logic [ADDR_W-3:0] word_addr;
        logic [DATA_W-1:0] wdata;
        logic [BE_W-1:0]   be;
    } sb_entry_t;

    // True when the access is not naturally aligned for its size
    function automatic logic is_misaligned(input logic [2:0] sel, input logic [1:0] lo);
        logic result;
        result = 1'b0;
        case (sel)
            ST_SB:   result = 1'b0;
            ST_SH:   result = lo[0];
            default: result = (lo != 2'b00);
        endcase
        return result;
    endfunction

endpackage

// File: rtl/store_fifo.sv
// Circular queue of store entries. Push is ignored while full (even with a
// simultaneous pop), pop is ignored while empty. Entry storage is not reset.
module store_fifo #(
    parameter int WIDTH = 66,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rd_data = mem_q[rd_ptr_q];

    // Next pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state, cleared immediately by reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage write, no reset needed
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Store buffer: formats core stores into word-aligned, lane-replicated writes
// with byte enables and queues them in order for memory.
// Optional feature macro: STORE_MISALIGN_TRAP_EN drops misaligned sh/sw stores
// after the handshake and pulses misalign the following cycle. Without it,
// misaligned stores are queued with the low address bits ignored.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              st_valid,
    output logic              st_ready,
    input  logic [2:0]        st_sel,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [DATA_W-1:0] st_data,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [BE_W-1:0]   mem_be,
    output logic              empty,
    output logic              misalign
);

    localparam int ENTRY_W = $bits(sb_entry_t);

    sb_entry_t         new_entry;
    sb_entry_t         head_entry;
    logic [DATA_W-1:0] fmt_wdata;
    logic [BE_W-1:0]   fmt_be;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push_hs;
    logic              fifo_push;
    logic              fifo_pop;

    assign st_ready  = !fifo_full;
    assign push_hs   = st_valid && st_ready;
    assign mem_valid = !fifo_empty;
    assign empty     = fifo_empty;
    assign fifo_pop  = mem_valid && mem_ready;

    // Size-dependent lane replication and byte-enable generation; unknown codes act as sw
    always_comb begin
        fmt_wdata = st_data;
        fmt_be    = 4'b1111;
        case (st_sel)
            ST_SB: begin
                fmt_wdata = {4{st_data[7:0]}};
                fmt_be    = 4'b0001 << st_addr[1:0];
            end
            ST_SH: begin
                fmt_wdata = {2{st_data[15:0]}};
                fmt_be    = st_addr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                fmt_wdata = st_data;
                fmt_be    = 4'b1111;
            end
        endcase
    end

    assign new_entry.word_addr = st_addr[ADDR_W-1:2];
    assign new_entry.wdata     = fmt_wdata;
    assign new_entry.be        = fmt_be;

`ifdef STORE_MISALIGN_TRAP_EN
    logic misalign_q, misalign_d;
    logic st_misaligned;

    assign st_misaligned = is_misaligned(st_sel, st_addr[1:0]);
    assign fifo_push     = push_hs && !st_misaligned;
    assign misalign      = misalign_q;

    // A misaligned store is consumed but not queued; flag it one cycle later
    always_comb begin
        misalign_d = push_hs && st_misaligned;
    end

    // Registered misalign pulse
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end
`else
    assign fifo_push = push_hs;
    assign misalign  = 1'b0;
`endif

    store_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (fifo_push),
        .wr_data (new_entry),
        .pop     (fifo_pop),
        .rd_data (head_entry),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign mem_addr  = {head_entry.word_addr, 2'b00};
    assign mem_wdata = head_entry.wdata;
    assign mem_be    = head_entry.be;

endmodule

// File: tb/tb_store_buffer.sv
// Directed testbench for store_buffer (DEPTH = 4).
module tb_store_buffer;

    logic        clk;
    logic        reset_n;
    logic        st_valid;
    logic        st_ready;
    logic [2:0]  st_sel;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        empty;
    logic        misalign;

    int checks = 0;
    int errors = 0;

    store_buffer #(.DEPTH(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .st_valid  (st_valid),
        .st_ready  (st_ready),
        .st_sel    (st_sel),
        .st_addr   (st_addr),
        .st_data   (st_data),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .empty     (empty),
        .misalign  (misalign)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
        end
    endtask

    // Drive all core/memory inputs at once
    task automatic applyStimulus(input logic v, input logic [2:0] sel, input logic [31:0] addr,
                                 input logic [31:0] data, input logic mrdy);
        st_valid  = v;
        st_sel    = sel;
        st_addr   = addr;
        st_data   = data;
        mem_ready = mrdy;
    endtask

    // Advance one rising edge, returning on the following falling edge
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        applyStimulus(1'b0, 3'b000, 32'h0, 32'h0, 1'b0);
        reset_n = 1'b0;
        #12;
        checkOutput("rst_empty", {31'b0, empty}, 32'd1);
        checkOutput("rst_mem_valid", {31'b0, mem_valid}, 32'd0);
        checkOutput("rst_st_ready", {31'b0, st_ready}, 32'd1);
        checkOutput("rst_misalign", {31'b0, misalign}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        // sb at byte 3 of word 0x1000
        applyStimulus(1'b1, 3'b000, 32'h0000_1003, 32'h0000_00AB, 1'b0);
        checkOutput("sb_no_bypass", {31'b0, mem_valid}, 32'd0);
        tick();
        applyStimulus(1'b0, 3'b000, 32'h0, 32'h0, 1'b0);
        checkOutput("sb_valid", {31'b0, mem_valid}, 32'd1);
        checkOutput("sb_addr", mem_addr, 32'h0000_1000);
        checkOutput("sb_wdata", mem_wdata, 32'hABAB_ABAB);
        checkOutput("sb_be", {28'b0, mem_be}, 32'h8);
        mem_ready = 1'b1;
        tick();
        checkOutput("sb_drained", {31'b0, empty}, 32'd1);

        // sh at upper half of word 0x2000
        applyStimulus(1'b1, 3'b001, 32'h0000_2002, 32'h0000_BEEF, 1'b0);
        tick();
        applyStimulus(1'b0, 3'b000, 32'h0, 32'h0, 1'b0);
        checkOutput("sh_addr", mem_addr, 32'h0000_2000);
        checkOutput("sh_wdata", mem_wdata, 32'hBEEF_BEEF);
        checkOutput("sh_be", {28'b0, mem_be}, 32'hC);
        mem_ready = 1'b1;
        tick();
        checkOutput("sh_drained", {31'b0, empty}, 32'd1);

        // Fill with four sw while memory stalls (pointers wrap here)
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 3'b010, 32'h100 + 32'(i * 4), 32'h1111_1111 * 32'(i + 1), 1'b0);
            checkOutput("fill_ready", {31'b0, st_ready}, 32'd1);
            tick();
        end
        checkOutput("full_not_ready", {31'b0, st_ready}, 32'd0);

        // Fifth store must be refused; head must stay stable under stall
        applyStimulus(1'b1, 3'b010, 32'h0000_0200, 32'hDEAD_DEAD, 1'b0);
        tick();
        checkOutput("full_still", {31'b0, st_ready}, 32'd0);
        checkOutput("stall_head_addr", mem_addr, 32'h0000_0100);
        checkOutput("stall_head_data", mem_wdata, 32'h1111_1111);

        // Full with push and pop together: only the pop happens
        applyStimulus(1'b1, 3'b010, 32'h0000_0300, 32'hBAD0_BAD0, 1'b1);
        tick();
        applyStimulus(1'b0, 3'b000, 32'h0, 32'h0, 1'b0);
        checkOutput("pushpop_ready", {31'b0, st_ready}, 32'd1);
        checkOutput("pushpop_head", mem_addr, 32'h0000_0104);

        // Drain remaining three in push order
        mem_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            checkOutput("drain_addr", mem_addr, 32'h100 + 32'(i * 4));
            checkOutput("drain_data", mem_wdata, 32'h1111_1111 * 32'(i + 1));
            checkOutput("drain_valid", {31'b0, mem_valid}, 32'd1);
            tick();
        end
        checkOutput("drain_empty", {31'b0, empty}, 32'd1);

        // mem_ready while empty does nothing
        tick();
        checkOutput("idle_ready_empty", {31'b0, empty}, 32'd1);
        mem_ready = 1'b0;

        // Misaligned sw at 0x3001
        applyStimulus(1'b1, 3'b010, 32'h0000_3001, 32'h1234_5678, 1'b0);
        tick();
        applyStimulus(1'b0, 3'b000, 32'h0, 32'h0, 1'b0);
`ifdef STORE_MISALIGN_TRAP_EN
        checkOutput("mis_pulse", {31'b0, misalign}, 32'd1);
        checkOutput("mis_not_queued", {31'b0, mem_valid}, 32'd0);
        tick();
        checkOutput("mis_pulse_end", {31'b0, misalign}, 32'd0);
        checkOutput("mis_still_empty", {31'b0, empty}, 32'd1);
`else
        checkOutput("mis_flag_low", {31'b0, misalign}, 32'd0);
        checkOutput("mis_addr", mem_addr, 32'h0000_3000);
        checkOutput("mis_be", {28'b0, mem_be}, 32'hF);
        checkOutput("mis_wdata", mem_wdata, 32'h1234_5678);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
`endif

        // Reserved size code behaves as sw
        applyStimulus(1'b1, 3'b111, 32'h0000_4000, 32'hCAFE_F00D, 1'b0);
        tick();
        applyStimulus(1'b0, 3'b000, 32'h0, 32'h0, 1'b0);
        checkOutput("rsv_be", {28'b0, mem_be}, 32'hF);
        checkOutput("rsv_wdata", mem_wdata, 32'hCAFE_F00D);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;

        // Two entries queued, then reset mid-cycle during a handshake
        applyStimulus(1'b1, 3'b000, 32'h0000_5001, 32'h0000_0055, 1'b0);
        tick();
        applyStimulus(1'b1, 3'b010, 32'h0000_5004, 32'h0000_0066, 1'b0);
        tick();
        applyStimulus(1'b0, 3'b000, 32'h0, 32'h0, 1'b1);
        checkOutput("pre_rst_valid", {31'b0, mem_valid}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("async_rst_valid", {31'b0, mem_valid}, 32'd0);
        checkOutput("async_rst_empty", {31'b0, empty}, 32'd1);
        checkOutput("async_rst_ready", {31'b0, st_ready}, 32'd1);
        @(negedge clk);
        reset_n = 1'b1;
        mem_ready = 1'b0;
        tick();
        checkOutput("post_rst_empty", {31'b0, empty}, 32'd1);

        // Fresh store after reset becomes head
        applyStimulus(1'b1, 3'b001, 32'h0000_6000, 32'h0000_A5A5, 1'b0);
        tick();
        applyStimulus(1'b0, 3'b000, 32'h0, 32'h0, 1'b0);
        checkOutput("post_rst_addr", mem_addr, 32'h0000_6000);
        checkOutput("post_rst_be", {28'b0, mem_be}, 32'h3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
